spi_upcounter_tx_ctrl: RTL and testbench

Sequencer that streams the up-counter status to an external SPI slave (remote display) through the existing SPI master byte engine.
- Schedules a 2-byte status frame periodically, and immediately when run/stop or clear state changes.
- Snapshots the counter, drives slave-select, and issues byte start strobes.
- Supervises completion with a watchdog.
- Sits between the counter control unit / counter datapath and the SPI master.

---
 rtl/spi_upcounter_pkg.sv | 26 ++
 rtl/spi_tick_gen.sv | 24 ++
 rtl/spi_upcounter_tx_ctrl.sv | 155 +++++++++++++++
 tb/tb_spi_upcounter_tx_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_upcounter_pkg.sv
// Shared types and frame layout for the up-counter SPI status streamer.
// The 2-byte frame carries {run, clear, count[13:8]} then count[7:0].
package spi_upcounter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        ABORT,
        GAP
    } tx_state_t;

    localparam int unsigned HI_RUN_BIT = 7;
    localparam int unsigned HI_CLR_BIT = 6;
    localparam int unsigned HI_CNT_MSB = 5;

    // Slave select is asserted from LOAD through WAIT_LO inclusive.
    function automatic logic ss_active(input tx_state_t s);
        return (s == LOAD) || (s == SEND_HI) || (s == WAIT_HI) ||
               (s == SEND_LO) || (s == WAIT_LO);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Free-running 0..PERIOD-1 counter; o_tick is high for the one wrap cycle.
module spi_tick_gen #(
    parameter int unsigned PERIOD = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        o_tick = (cnt_q == CW'(PERIOD - 1));
        cnt_d  = o_tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_upcounter_tx_ctrl.sv
// Streams {run, clear, count} to a remote SPI display via the byte engine:
// periodic and change-triggered frames, snapshot per frame, done watchdog.
module spi_upcounter_tx_ctrl
    import spi_upcounter_pkg::*;
#(
    parameter int unsigned CNT_W   = 14,
    parameter int unsigned PERIOD  = 1_000_000,
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_runstop,
    input  logic             i_clear,
    input  logic             i_tx_ready,
    input  logic             i_tx_done,
    output logic             o_tx_start,
    output logic [7:0]       o_tx_data,
    output logic             o_ss_n,
    output logic             o_busy,
    output logic [15:0]      o_frame_cnt,
    output logic             o_err
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);

    tx_state_t         state_q, state_d;
    logic              pending_q, pending_d;
    logic              rs_hist_q, clr_hist_q;
    logic [7:0]        lo_shadow_q, lo_shadow_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              ss_n_q, ss_n_d;
    logic              start_q, start_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic [15:0]       frame_q, frame_d;
    logic              err_q, err_d;
    logic              tick;
    logic              flag_event;
    logic              wait_tmo;

    spi_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (tick)
    );

    assign flag_event = (i_runstop != rs_hist_q) || (i_clear != clr_hist_q);
    assign wait_tmo   = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        pending_d   = tick || flag_event || (pending_q && (state_q != LOAD));
        lo_shadow_d = lo_shadow_q;
        wait_d      = wait_q;
        gap_d       = '0;
        frame_d     = frame_q;

        case (state_q)
            IDLE:    if (pending_q && i_tx_ready) state_d = LOAD;
            LOAD: begin
                lo_shadow_d = i_count[7:0];
                state_d     = SEND_HI;
            end
            SEND_HI: begin
                wait_d  = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                wait_d = wait_q + WAIT_W'(1);
                if (i_tx_done)     state_d = SEND_LO;
                else if (wait_tmo) state_d = ABORT;
            end
            SEND_LO: begin
                wait_d  = '0;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                wait_d = wait_q + WAIT_W'(1);
                if (i_tx_done) begin
                    frame_d = frame_q + 16'd1;
                    state_d = GAP;
                end else if (wait_tmo) begin
                    state_d = ABORT;
                end
            end
            ABORT:   state_d = GAP;
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state. The high byte is built from
        // the live LOAD-cycle inputs, which are exactly what the snapshot holds.
        ss_n_d  = !ss_active(state_d);
        start_d = (state_d == SEND_HI) || (state_d == SEND_LO);
        busy_d  = (state_d != IDLE);
        err_d   = err_q || (state_d == ABORT);
        data_d  = '0;
        if (state_d == SEND_HI) begin
            data_d[HI_RUN_BIT]     = i_runstop;
            data_d[HI_CLR_BIT]     = i_clear;
            data_d[HI_CNT_MSB:0]   = i_count[HI_CNT_MSB+8:8];
        end else if (state_d == SEND_LO) begin
            data_d = lo_shadow_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            rs_hist_q   <= 1'b0;
            clr_hist_q  <= 1'b0;
            lo_shadow_q <= '0;
            wait_q      <= '0;
            gap_q       <= '0;
            ss_n_q      <= 1'b1;
            start_q     <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            frame_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rs_hist_q   <= i_runstop;
            clr_hist_q  <= i_clear;
            lo_shadow_q <= lo_shadow_d;
            wait_q      <= wait_d;
            gap_q       <= gap_d;
            ss_n_q      <= ss_n_d;
            start_q     <= start_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
        end
    end

    assign o_ss_n      = ss_n_q;
    assign o_tx_start  = start_q;
    assign o_tx_data   = data_q;
    assign o_busy      = busy_q;
    assign o_frame_cnt = frame_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_spi_upcounter_tx_ctrl.sv
// Directed bench: SPI master model plus a frame scoreboard fed from the
// inputs seen at each LOAD, checking bytes, latency, watchdog and wrap.
module tb_spi_upcounter_tx_ctrl;

    localparam int DONE_DLY = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] i_count;
    logic        i_runstop, i_clear, i_tx_ready;
    logic        i_tx_done = 1'b0;
    logic        o_tx_start, o_ss_n, o_busy, o_err;
    logic [7:0]  o_tx_data;
    logic [15:0] o_frame_cnt;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          n_loads  = 0;
    int          n_starts = 0;
    int          n_lo     = 0;
    int          last_load_cyc  = 0;
    int          last_start_cyc = 0;
    logic [15:0] exp_frames = '0;
    logic        done_en = 1'b1;
    logic        inc_en  = 1'b0;
    int          stray_req = 0;
    logic [7:0]  exp_q[$];

    spi_upcounter_tx_ctrl #(
        .CNT_W   (14),
        .PERIOD  (20),
        .GAP_CYC (2),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_count     (i_count),
        .i_runstop   (i_runstop),
        .i_clear     (i_clear),
        .i_tx_ready  (i_tx_ready),
        .i_tx_done   (i_tx_done),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_ss_n      (o_ss_n),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt),
        .o_err       (o_err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        if (inc_en) i_count = i_count + 14'd1;
    endtask

    task automatic wait_loads(input int target, input int budget, input string tag);
        int k = 0;
        while (n_loads < target && k < budget) begin step(); k++; end
        check(tag, 32'(n_loads >= target), 1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int k = 0;
        while (n_starts < target && k < budget) begin step(); k++; end
        check(tag, 32'(n_starts >= target), 1);
    endtask

    task automatic wait_lo(input int target, input int budget, input string tag);
        int k = 0;
        while (n_lo < target && k < budget) begin step(); k++; end
        check(tag, 32'(n_lo >= target), 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (o_busy !== 1'b0 && k < budget) begin step(); k++; end
        check(tag, 32'(o_busy), 0);
    endtask

    // SPI master model: answers each strobe with a done pulse DONE_DLY later
    initial begin : master
        int cd = 0;
        int nbyte = 0;
        int stray_seen = 0;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (reset) begin
                cd = 0;
                nbyte = 0;
                exp_frames = '0;
            end else begin
                if (stray_req != stray_seen) begin
                    stray_seen = stray_req;
                    i_tx_done = 1'b1;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        i_tx_done = 1'b1;
                        if (nbyte == 2) begin
                            exp_frames = exp_frames + 16'd1;
                            nbyte = 0;
                        end
                    end
                end
                if (o_tx_start) begin
                    nbyte++;
                    if (done_en) cd = DONE_DLY;
                end else if (o_ss_n && cd == 0) begin
                    nbyte = 0;
                end
            end
        end
    end

    // Scoreboard: expected bytes come from the inputs the DUT samples at the
    // end of the LOAD cycle; every strobe pops and compares one byte.
    initial begin : monitor
        logic       prev_ss = 1'b1;
        logic       ss_now;
        int         byte_idx = 0;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                byte_idx = 0;
                prev_ss = 1'b1;
            end else begin
                ss_now = o_ss_n;
                if (o_tx_start) begin
                    n_starts++;
                    last_start_cyc = cyc;
                    byte_idx++;
                    if (byte_idx == 2) n_lo++;
                    check("ss_n_at_strobe", 32'(o_ss_n), 0);
                    check("strobe_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check("tx_byte", 32'(o_tx_data), 32'(exp_b));
                    end
                end
                if (prev_ss && !ss_now) begin
                    n_loads++;
                    last_load_cyc = cyc;
                    byte_idx = 0;
                    exp_q.delete();
                    @(posedge clk);
                    exp_q.push_back({i_runstop, i_clear, i_count[13:8]});
                    exp_q.push_back(i_count[7:0]);
                end
                prev_ss = ss_now;
            end
        end
    end

    initial begin : main
        int t0;
        int a;
        int tl[3];
        logic [15:0] fbefore;

        reset = 1'b1;
        i_count = 14'h1ABC;
        i_runstop = 1'b0;
        i_clear = 1'b0;
        i_tx_ready = 1'b1;
        repeat (3) step();
        check("rst_ss_n", 32'(o_ss_n), 1);
        check("rst_tx_start", 32'(o_tx_start), 0);
        check("rst_tx_data", 32'(o_tx_data), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_frame_cnt", 32'(o_frame_cnt), 0);
        check("rst_err", 32'(o_err), 0);
        reset = 1'b0;

        // first periodic frame, then run 0->1 event from idle
        wait_loads(n_loads + 1, 40, "first_tick_frame");
        wait_idle(30, "idle_after_first");
        t0 = cyc;
        i_runstop = 1'b1;
        wait_loads(n_loads + 1, 10, "event_frame");
        check("event_load_latency", 32'(last_load_cyc - t0), 2);
        wait_starts(n_starts + 1, 5, "event_start");
        check("event_start_latency", 32'(last_start_cyc - t0), 3);
        step();
        i_runstop = 1'b0;
        repeat (2) step();
        i_runstop = 1'b1;
        wait_idle(30, "idle_after_event");
        a = n_loads;
        repeat (12) step();
        check("coalesced_followups", 32'(n_loads - a), 1);
        check("frames_after_events", 32'(o_frame_cnt), 32'(exp_frames));

        // periodic frames, bytes 0x9A 0xBC
        for (int i = 0; i < 3; i++) begin
            wait_loads(n_loads + 1, 30, "periodic_frame");
            tl[i] = last_load_cyc;
            wait_idle(20, "periodic_idle");
            check("frame_cnt_periodic", 32'(o_frame_cnt), 32'(exp_frames));
        end
        check("period_a", 32'(tl[1] - tl[0]), 20);
        check("period_b", 32'(tl[2] - tl[1]), 20);

        // snapshot while the count moves every cycle
        inc_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_loads(n_loads + 1, 30, "snapshot_frame");
            wait_idle(20, "snapshot_idle");
        end
        inc_en = 1'b0;
        check("frame_cnt_snapshot", 32'(o_frame_cnt), 32'(exp_frames));

        // watchdog: no done from the master
        done_en = 1'b0;
        fbefore = exp_frames;
        wait_starts(n_starts + 1, 40, "wdog_start");
        while (cyc < last_start_cyc + 16) step();
        check("wdog_err_before", 32'(o_err), 0);
        check("wdog_ss_before", 32'(o_ss_n), 0);
        step();
        check("wdog_err_set", 32'(o_err), 1);
        check("wdog_ss_high", 32'(o_ss_n), 1);
        check("wdog_busy_abort", 32'(o_busy), 1);
        check("wdog_frame_cnt", 32'(o_frame_cnt), 32'(fbefore));
        done_en = 1'b1;
        wait_loads(n_loads + 1, 40, "wdog_recover_frame");
        wait_idle(30, "wdog_recover_idle");
        check("wdog_recover_cnt", 32'(o_frame_cnt), 32'(exp_frames));
        check("err_sticky", 32'(o_err), 1);
        stray_req++;
        repeat (3) step();
        check("stray_done_ignored", 32'(o_frame_cnt), 32'(exp_frames));

        // backpressure across three ticks
        wait_idle(30, "bp_idle");
        i_tx_ready = 1'b0;
        a = n_loads;
        repeat (65) step();
        check("bp_no_frame", 32'(n_loads - a), 0);
        check("bp_busy", 32'(o_busy), 0);
        t0 = cyc;
        i_tx_ready = 1'b1;
        wait_loads(a + 1, 5, "bp_frame");
        check("bp_latency", 32'(last_load_cyc - t0), 1);

        // asynchronous reset in WAIT_LO
        wait_lo(n_lo + 1, 20, "reach_wait_lo");
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_ss_n", 32'(o_ss_n), 1);
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_frame_cnt", 32'(o_frame_cnt), 0);
        check("mid_rst_start", 32'(o_tx_start), 0);
        check("mid_rst_err", 32'(o_err), 0);
        a = n_starts;
        repeat (3) step();
        check("no_strobe_in_reset", 32'(n_starts - a), 0);
        reset = 1'b0;

        // frame counter wrap
        wait_loads(n_loads + 1, 40, "post_rst_frame");
        wait_idle(30, "post_rst_idle");
        check("post_rst_frame_cnt", 32'(o_frame_cnt), 32'(exp_frames));
        force dut.frame_q = 16'hFFFF;
        step();
        release dut.frame_q;
        step();
        check("wrap_preload", 32'(o_frame_cnt), 32'h0000_FFFF);
        wait_loads(n_loads + 1, 40, "wrap_frame");
        wait_idle(30, "wrap_idle");
        check("frame_cnt_wrap", 32'(o_frame_cnt), 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
